// File: rtl/arb_pkg.sv
// Shared constants for locking_bus_arbiter: FSM state encodings and the
// index-width helper used by the interface, picker and top level.
package arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Never returns 0, so a parameter of 1 still gives a legal 1-bit vector.
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/locking_bus_arbiter_if.sv
// Request/grant bundle between the bus masters and locking_bus_arbiter.
// master: driven by the requesters; slave: driven by the arbiter.
interface locking_bus_arbiter_if
    import arb_pkg::*;
#(
    parameter int N = 4
) ();

    localparam int IDW = clog2w(N);

    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] owner_id;
    logic           timeout_pulse;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  owner_id,
        input  timeout_pulse
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output owner_id,
        output timeout_pulse
    );

endinterface

// File: rtl/locking_bus_arbiter_prio_pick.sv
// Combinational fixed-priority picker: the highest set request bit wins.
// Produces a one-hot vector, its binary index and an any-request flag.
module prio_pick
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    output logic [N-1:0]          onehot,
    output logic [clog2w(N)-1:0]  idx,
    output logic                  any
);

    localparam int IDW = clog2w(N);

    // Ascending scan: later (higher) indices overwrite earlier ones.
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/locking_bus_arbiter.sv
// Fixed-priority locking bus arbiter: a grant is held until its owner drops req.
// Define ARB_TIMEOUT_EN to add a MAX_HOLD tenure limit with forced release and masking.
module locking_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N          = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input logic                  clk,
    input logic                  rst,
    locking_bus_arbiter_if.slave bus
);

    localparam int IDW = clog2w(N);
    localparam int GW  = clog2w(TURNAROUND + 1);

    if (N < 2 || TURNAROUND < 0 || MAX_HOLD < 1) begin : g_param_check
        $error("locking_bus_arbiter: requires N>=2, TURNAROUND>=0, MAX_HOLD>=1");
    end

    logic [1:0]     state;
    logic [GW-1:0]  gap_cnt;
    logic [N-1:0]   grant_q;
    logic           grant_valid_q;
    logic [IDW-1:0] owner_q;

    logic [N-1:0]   cand;
    logic [N-1:0]   pick_onehot;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;
    logic           owner_req;
    logic           forced;
    logic           release_now;

    assign owner_req = bus.req[owner_q];

`ifdef ARB_TIMEOUT_EN
    localparam int HW = clog2w(MAX_HOLD + 1);

    logic [HW-1:0] hold_cnt;
    logic [N-1:0]  mask;
    logic          hold_expired;
    logic          timeout_q;

    // A masked master is only passed over when someone else is asking.
    assign cand         = ((bus.req & ~mask) != '0) ? (bus.req & ~mask) : bus.req;
    assign hold_expired = (hold_cnt >= HW'(MAX_HOLD));
    assign forced       = owner_req && hold_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            mask      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state == ST_IDLE && pick_any) begin
                hold_cnt <= HW'(1);
                mask     <= '0;
            end else if (state == ST_GRANT) begin
                if (forced) begin
                    timeout_q <= 1'b1;
                    mask      <= grant_q;
                    hold_cnt  <= '0;
                end else if (!owner_req) begin
                    hold_cnt <= '0;
                end else if (!hold_expired) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.timeout_pulse = timeout_q;
`else
    assign cand              = bus.req;
    assign forced            = 1'b0;
    assign bus.timeout_pulse = 1'b0;
`endif

    assign release_now = !owner_req || forced;

    prio_pick #(
        .N(N)
    ) u_pick (
        .req    (cand),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grant is frozen in ST_GRANT; every handoff passes through at least one
    // grant=0 cycle (ST_GAP and/or ST_IDLE), so grant never jumps one-hot to one-hot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            gap_cnt       <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            owner_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q       <= pick_onehot;
                        grant_valid_q <= 1'b1;
                        owner_q       <= pick_idx;
                        state         <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        owner_q       <= '0;
                        gap_cnt       <= '0;
                        state         <= (TURNAROUND > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (int'(gap_cnt) >= TURNAROUND - 1) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.owner_id    = owner_q;

endmodule

// File: tb/tb_locking_bus_arbiter.sv
// Scoreboard bench for locking_bus_arbiter (N=4, TURNAROUND=1, MAX_HOLD=16);
// the timeout scenarios switch on ARB_TIMEOUT_EN like the design does.
module tb_locking_bus_arbiter;

    typedef struct {
        int         cyc;
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total_checks = 0;
    int   passed_checks = 0;
    exp_t sb[$];
    exp_t mon_e;

    locking_bus_arbiter_if #(.N(4)) bus ();

    locking_bus_arbiter #(
        .N          (4),
        .TURNAROUND (1),
        .MAX_HOLD   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] observed();
        return {bus.grant, bus.grant_valid, bus.owner_id, bus.timeout_pulse};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got {grant,gv,owner,tp}=%b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drive req now and expect the given outputs after the next edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] g, input logic [1:0] o,
                                 input logic t, input string name);
        exp_t e;
        bus.req = r;
        e.cyc   = cyc + 1;
        e.exp   = {g, |g, o, t};
        e.name  = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops every expectation due this cycle and compares it with the DUT.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc < cyc) begin
                total_checks++;
                $display("[TB] FAIL %s: expectation for cycle %0d never sampled (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else begin
                checkOutput(mon_e.name, observed(), mon_e.exp);
            end
        end
    end

    initial begin
        bus.req = 4'b1111;
        #1;
        rst = 1'b1;
        #1;
        $display("[TB] reset with all masters requesting");
        checkOutput("reset_async", observed(), 8'h00);
        @(posedge clk);
        #1;
        checkOutput("reset_held_over_edge", observed(), 8'h00);
        rst = 1'b0;

        applyStimulus(4'b1111, 4'b1000, 2'd3, 1'b0, "t1_first_grant_m3");
        applyStimulus(4'b1111, 4'b1000, 2'd3, 1'b0, "t1_hold_m3");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t1_release");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t1_gap");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t1_idle_no_req");

        $display("[TB] hold against higher priority");
        applyStimulus(4'b0010, 4'b0010, 2'd1, 1'b0, "t2_grant_m1");
        for (int i = 0; i < 3; i++)
            applyStimulus(4'b1010, 4'b0010, 2'd1, 1'b0, "t2_no_preempt");
        applyStimulus(4'b1000, 4'b0000, 2'd0, 1'b0, "t2_release_m1");
        applyStimulus(4'b1000, 4'b0000, 2'd0, 1'b0, "t2_gap");
        applyStimulus(4'b1000, 4'b1000, 2'd3, 1'b0, "t2_handoff_m3");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t2_release_m3");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t2_gap2");

        $display("[TB] single requester tenure");
        for (int i = 0; i < 5; i++)
            applyStimulus(4'b0001, 4'b0001, 2'd0, 1'b0, "t3_m0_tenure");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t3_release_no_pulse");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t3_gap");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t3_idle");

        $display("[TB] async reset mid-tenure");
        applyStimulus(4'b0100, 4'b0100, 2'd2, 1'b0, "t4_grant_m2");
        applyStimulus(4'b0100, 4'b0100, 2'd2, 1'b0, "t4_hold_m2");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t4_async_reset_immediate", observed(), 8'h00);
        @(posedge clk);
        #1;
        checkOutput("t4_reset_dominates_req", observed(), 8'h00);
        rst     = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t4_after_reset_idle");

`ifdef ARB_TIMEOUT_EN
        $display("[TB] forced release and masking");
        for (int i = 0; i < 16; i++)
            applyStimulus(4'b1001, 4'b1000, 2'd3, 1'b0, "t5_m3_tenure");
        applyStimulus(4'b1001, 4'b0000, 2'd0, 1'b1, "t5_timeout_pulse");
        applyStimulus(4'b1001, 4'b0000, 2'd0, 1'b0, "t5_gap");
        applyStimulus(4'b1001, 4'b0001, 2'd0, 1'b0, "t5_masked_m3_m0_wins");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t5_release_m0");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t5_gap2");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t5_idle");

        $display("[TB] sole requester re-granted after timeout");
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 16; i++)
                applyStimulus(4'b0100, 4'b0100, 2'd2, 1'b0, "t6_m2_tenure");
            applyStimulus(4'b0100, 4'b0000, 2'd0, 1'b1, "t6_timeout_pulse");
            applyStimulus(4'b0100, 4'b0000, 2'd0, 1'b0, "t6_gap");
        end
        applyStimulus(4'b0100, 4'b0100, 2'd2, 1'b0, "t6_regrant_m2");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t6_release");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t6_gap2");
`else
        $display("[TB] unlimited tenure");
        for (int i = 0; i < 20; i++)
            applyStimulus(4'b1001, 4'b1000, 2'd3, 1'b0, "t5_m3_unlimited");
        applyStimulus(4'b0001, 4'b0000, 2'd0, 1'b0, "t5_release_m3");
        applyStimulus(4'b0001, 4'b0000, 2'd0, 1'b0, "t5_gap");
        applyStimulus(4'b0001, 4'b0001, 2'd0, 1'b0, "t5_m0_next");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t5_release_m0");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t5_gap2");

        for (int i = 0; i < 20; i++)
            applyStimulus(4'b0100, 4'b0100, 2'd2, 1'b0, "t6_m2_persists");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t6_release");
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "t6_gap");
`endif
        applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "final_idle");

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 8'(sb.size()), 8'h00);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
